// File: rtl/neuron_frame_sequencer_if.sv
// neuron_frame_sequencer_if: line-memory read bus plus result valid/ready handshake; master = sequencer, slave = memory/host
interface neuron_frame_sequencer_if #(parameter int ADDR_W = 10, parameter int LINE_W = 224);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        class_idx;
  logic [31:0]       class_score;
  modport master (output mem_rd_en, mem_addr, out_valid, class_idx, class_score, input mem_rd_data, out_ready);
  modport slave (input mem_rd_en, mem_addr, out_valid, class_idx, class_score, output mem_rd_data, out_ready);
endinterface

// File: rtl/neuron_frame_sequencer.sv
// neuron_frame_sequencer: fetch 7 rows -> strobe neuron_unit -> wait latency -> fp32 argmax -> host; ports: clk/reset(async low), start/frame_base in, bus (memory + result handshake), line_k_out/de_out to neuron_unit, symbol_k_in back, busy/frame_count status
module neuron_frame_sequencer #(
  parameter int NUM_LINES   = 7,
  parameter int LINE_W      = 224,
  parameter int ADDR_W      = 10,
  parameter int NET_LATENCY = 8,
  parameter int NUM_CLASSES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         frame_base,
  output logic                      busy,
  neuron_frame_sequencer_if.master  bus,
  output logic [LINE_W-1:0]         line_0_out,
  output logic [LINE_W-1:0]         line_1_out,
  output logic [LINE_W-1:0]         line_2_out,
  output logic [LINE_W-1:0]         line_3_out,
  output logic [LINE_W-1:0]         line_4_out,
  output logic [LINE_W-1:0]         line_5_out,
  output logic [LINE_W-1:0]         line_6_out,
  output logic                      de_out,
  input  logic [31:0]               symbol_0_in,
  input  logic [31:0]               symbol_1_in,
  input  logic [31:0]               symbol_2_in,
  input  logic [31:0]               symbol_3_in,
  output logic [15:0]               frame_count
);
  localparam int KW = $clog2(NUM_LINES);
  localparam int CW = $clog2(NUM_CLASSES);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, FIRE, WAIT, CAPTURE, CMP, RESULT} state_t;
  state_t st, nxt;
  logic [ADDR_W-1:0] base;
  logic [KW-1:0] k, rd_k;
  logic rd_v;
  logic [7:0] cnt;
  logic [LINE_W-1:0] line_q [NUM_LINES];
  logic [31:0] sym_q [NUM_CLASSES];
  logic [31:0] best;
  logic [CW-1:0] best_idx;
  function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] == '0 && b[30:0] == '0) ? 1'b0 :
           (a[31] != b[31]) ? !a[31] :
           a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
  endfunction
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = (k == KW'(NUM_LINES - 1)) ? DRAIN : FETCH;
      DRAIN:   nxt = FIRE;
      FIRE:    nxt = (NET_LATENCY == 1) ? CAPTURE : WAIT;
      WAIT:    nxt = (cnt == 8'd1) ? CAPTURE : WAIT;
      CAPTURE: nxt = CMP;
      CMP:     nxt = (k == KW'(NUM_CLASSES - 1)) ? RESULT : CMP;
      RESULT:  nxt = bus.out_ready ? IDLE : RESULT;
      default: nxt = IDLE;
    endcase
  end
  assign busy            = st != IDLE;
  assign bus.mem_rd_en   = st == FETCH;
  assign bus.mem_addr    = (st == FETCH) ? base + ADDR_W'(k) : '0;
  assign de_out          = st == FIRE;
  assign bus.out_valid   = st == RESULT;
  assign bus.class_idx   = best_idx;
  assign bus.class_score = best;
  assign line_0_out = line_q[0];
  assign line_1_out = line_q[1];
  assign line_2_out = line_q[2];
  assign line_3_out = line_q[3];
  assign line_4_out = line_q[4];
  assign line_5_out = line_q[5];
  assign line_6_out = line_q[6];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      base        <= '0;
      k           <= '0;
      rd_k        <= '0;
      rd_v        <= 1'b0;
      cnt         <= '0;
      line_q      <= '{default: '0};
      sym_q       <= '{default: '0};
      best        <= '0;
      best_idx    <= '0;
      frame_count <= '0;
    end else begin
      st   <= nxt;
      // read data returns one cycle after the request, so the row index travels alongside it
      rd_v <= st == FETCH;
      rd_k <= k;
      if (rd_v) line_q[rd_k] <= bus.mem_rd_data;
      case (st)
        IDLE: if (start) begin
          base <= frame_base;
          k    <= '0;
        end
        FETCH: k <= k + 1'b1;
        FIRE:  cnt <= 8'(NET_LATENCY - 1);
        WAIT:  cnt <= cnt - 1'b1;
        CAPTURE: begin
          sym_q    <= '{symbol_0_in, symbol_1_in, symbol_2_in, symbol_3_in};
          best     <= symbol_0_in;
          best_idx <= '0;
          k        <= KW'(1);
        end
        CMP: begin
          // strict greater-than so ties keep the lower index
          if (gt(sym_q[k[CW-1:0]], best)) begin
            best     <= sym_q[k[CW-1:0]];
            best_idx <= k[CW-1:0];
          end
          k <= k + 1'b1;
        end
        RESULT: if (bus.out_ready) frame_count <= frame_count + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_frame_sequencer.sv
// tb_neuron_frame_sequencer: directed frames with cycle-exact checks of fetch, strobe, capture, argmax and handshake
module tb_neuron_frame_sequencer;
  localparam int LAT = 8;
  localparam logic [31:0] GARB = 32'h7F7F_FFFF;
  logic clk = 0, reset = 1, start = 0, busy, de_out;
  logic [9:0] frame_base = '0;
  logic [223:0] line [7];
  logic [31:0] sym [4] = '{GARB, GARB, GARB, GARB};
  logic [15:0] frame_count, exp_fc = '0;
  int n_cmp = 0, n_err = 0;
  neuron_frame_sequencer_if #(.ADDR_W(10), .LINE_W(224)) bus ();
  neuron_frame_sequencer #(.NET_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_base(frame_base), .busy(busy), .bus(bus),
    .line_0_out(line[0]), .line_1_out(line[1]), .line_2_out(line[2]), .line_3_out(line[3]),
    .line_4_out(line[4]), .line_5_out(line[5]), .line_6_out(line[6]), .de_out(de_out),
    .symbol_0_in(sym[0]), .symbol_1_in(sym[1]), .symbol_2_in(sym[2]), .symbol_3_in(sym[3]),
    .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  function automatic logic [223:0] row(input logic [9:0] a);
    logic [9:0] d;
    d = a - 10'h010;
    return {7{32'h3F80_0000 + {22'd0, d}}};
  endfunction
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= row(bus.mem_addr);
  task tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_frame(input logic [9:0] b, input logic [31:0] s0, s1, s2, s3,
                          input logic [1:0] e_idx, input logic [31:0] e_score, input int hold);
    logic [9:0] a;
    frame_base = b;
    start = 1;
    bus.out_ready = (hold == 0);
    tick;
    start = 0;
    for (int k = 0; k < 7; k++) begin
      a = b + 10'(k);
      n_cmp++;
      if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== a || busy !== 1'b1) begin
        n_err++;
        $display("FAIL fetch[%0d]: rd_en=%b addr=%h busy=%b, expected 1 %h 1", k, bus.mem_rd_en, bus.mem_addr, busy, a);
      end
      tick;
    end
    n_cmp++;
    if (bus.mem_rd_en !== 1'b0 || de_out !== 1'b0) begin
      n_err++;
      $display("FAIL drain: rd_en=%b de=%b, expected 0 0", bus.mem_rd_en, de_out);
    end
    tick;
    n_cmp++;
    if (de_out !== 1'b1) begin
      n_err++;
      $display("FAIL fire: de=%b, expected 1", de_out);
    end
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (line[k] !== row(b + 10'(k))) begin
        n_err++;
        $display("FAIL line[%0d]: got %h expected %h", k, line[k][31:0], row(b + 10'(k)) & 224'hFFFF_FFFF);
      end
    end
    tick;
    for (int c = 10; c < 9 + LAT; c++) begin
      n_cmp++;
      if (de_out !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL wait c%0d: de=%b valid=%b busy=%b, expected 0 0 1", c, de_out, bus.out_valid, busy);
      end
      tick;
    end
    sym = '{s0, s1, s2, s3};
    tick;
    sym = '{GARB, GARB, GARB, GARB};
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b0 || de_out !== 1'b0) begin
        n_err++;
        $display("FAIL cmp c%0d: valid=%b de=%b, expected 0 0", c, bus.out_valid, de_out);
      end
      tick;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.class_idx !== e_idx || bus.class_score !== e_score || busy !== 1'b1 || frame_count !== exp_fc) begin
      n_err++;
      $display("FAIL result: valid=%b idx=%0d score=%h busy=%b fc=%h, expected 1 %0d %h 1 %h",
               bus.out_valid, bus.class_idx, bus.class_score, busy, frame_count, e_idx, e_score, exp_fc);
    end
    for (int h = 0; h < hold; h++) begin
      start = h[0];
      tick;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.class_idx !== e_idx || bus.class_score !== e_score || busy !== 1'b1 || bus.mem_rd_en !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: valid=%b idx=%0d score=%h busy=%b rd_en=%b, expected 1 %0d %h 1 0",
                 h, bus.out_valid, bus.class_idx, bus.class_score, busy, bus.mem_rd_en, e_idx, e_score);
      end
    end
    bus.out_ready = 1;
    start = 1;
    tick;
    start = 0;
    exp_fc++;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== exp_fc) begin
      n_err++;
      $display("FAIL accept: valid=%b busy=%b fc=%h, expected 0 0 %h", bus.out_valid, busy, frame_count, exp_fc);
    end
    for (int c = 0; c < 3; c++) begin
      tick;
      n_cmp++;
      if (bus.mem_rd_en !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle[%0d]: rd_en=%b busy=%b, expected 0 0", c, bus.mem_rd_en, busy);
      end
    end
  endtask
  task test_reset;
    #3 reset = 0;
    #1;
    n_cmp++;
    if (busy !== 0 || de_out !== 0 || bus.mem_rd_en !== 0 || bus.mem_addr !== 0 || bus.out_valid !== 0 ||
        bus.class_idx !== 0 || bus.class_score !== 0 || frame_count !== 0 || line[0] !== 0 || line[6] !== 0) begin
      n_err++;
      $display("FAIL reset: busy=%b de=%b rd_en=%b valid=%b fc=%h, expected all 0", busy, de_out, bus.mem_rd_en, bus.out_valid, frame_count);
    end
    tick;
    tick;
    reset = 1;
    tick;
  endtask
  task test_basic;
    do_frame(10'h010, 32'h3F80_0000, 32'h4060_0000, 32'hC000_0000, 32'h3F00_0000, 2'd1, 32'h4060_0000, 0);
  endtask
  task test_neg_zero;
    do_frame(10'h010, 32'hBF80_0000, 32'hBF00_0000, 32'hC040_0000, 32'h8000_0000, 2'd3, 32'h8000_0000, 0);
    do_frame(10'h010, 32'h0000_0000, 32'h8000_0000, 32'hBF80_0000, 32'hC000_0000, 2'd0, 32'h0000_0000, 0);
  endtask
  task test_backpressure;
    do_frame(10'h020, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 2'd2, 32'h4000_0000, 20);
  endtask
  task test_addr_wrap;
    do_frame(10'h3FD, 32'hC000_0000, 32'hBF80_0000, 32'hC040_0000, 32'hC080_0000, 2'd1, 32'hBF80_0000, 0);
  endtask
  task test_reset_mid;
    frame_base = 10'h030;
    start = 1;
    tick;
    start = 0;
    repeat (11) tick;
    #2 reset = 0;
    #1;
    n_cmp++;
    if (busy !== 0 || de_out !== 0 || bus.mem_rd_en !== 0 || bus.mem_addr !== 0 || bus.out_valid !== 0 ||
        bus.class_idx !== 0 || bus.class_score !== 0 || frame_count !== 0 || line[0] !== 0 || line[6] !== 0) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b idx=%0d score=%h fc=%h line0=%h, expected all 0", busy, bus.class_idx, bus.class_score, frame_count, line[0][31:0]);
    end
    tick;
    tick;
    reset = 1;
    exp_fc = '0;
    for (int c = 0; c < 30; c++) begin
      tick;
      n_cmp++;
      if (bus.out_valid !== 0 || busy !== 0 || bus.mem_rd_en !== 0 || frame_count !== 0) begin
        n_err++;
        $display("FAIL post_reset[%0d]: valid=%b busy=%b rd_en=%b fc=%h, expected 0 0 0 0", c, bus.out_valid, busy, bus.mem_rd_en, frame_count);
      end
    end
    do_frame(10'h010, 32'h3F80_0000, 32'h4060_0000, 32'hC000_0000, 32'h3F00_0000, 2'd1, 32'h4060_0000, 0);
  endtask
  task test_count_wrap;
    force dut.frame_count = 16'hFFFF;
    #1 release dut.frame_count;
    exp_fc = 16'hFFFF;
    n_cmp++;
    if (frame_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL preload: fc=%h expected ffff", frame_count);
    end
    do_frame(10'h010, 32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 2'd3, 32'h4080_0000, 0);
  endtask
  initial begin
    bus.out_ready = 1;
    test_reset;
    test_basic;
    test_neg_zero;
    test_backpressure;
    test_addr_wrap;
    test_reset_mid;
    test_count_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
